// File: rtl/tile_frame_writer_if.sv
// Pixel-stream / tile-commit bundle between the pixel source, the tile writer and the frame buffer.
// No latency of its own; it is just wires.
// Backpressure: o_pixel_ready qualifies i_pixel_valid; the commit side has no backpressure.
interface tile_frame_writer_if;
  logic          i_frame_start;
  logic          i_pixel_valid;
  logic          o_pixel_ready;
  logic [7:0]    i_pixel_color;
  logic          o_sm_render_done;
  logic [5:0]    o_current_tile_x;
  logic [5:0]    o_current_tile_y;
  logic [2047:0] o_sm_color_data;
  logic          o_frame_done;

  // Pixel source / frame buffer side
  modport master (
    output i_frame_start,
    output i_pixel_valid,
    output i_pixel_color,
    input  o_pixel_ready,
    input  o_sm_render_done,
    input  o_current_tile_x,
    input  o_current_tile_y,
    input  o_sm_color_data,
    input  o_frame_done
  );

  // Tile writer side
  modport slave (
    input  i_frame_start,
    input  i_pixel_valid,
    input  i_pixel_color,
    output o_pixel_ready,
    output o_sm_render_done,
    output o_current_tile_x,
    output o_current_tile_y,
    output o_sm_color_data,
    output o_frame_done
  );
endinterface

// File: rtl/tile_frame_writer.sv
// Collects 256 pixels into a 16x16 tile register and strobes it, with successor coordinates, to the frame buffer.
// Latency: strobe is asserted 1 cycle after the 256th pixel is accepted; all outputs registered.
// Backpressure: ready is high only in FILL; it drops for the single commit cycle and while idle.
module tile_frame_writer #(
  parameter int TILES_X = 40,
  parameter int TILES_Y = 30
) (
  input  logic              clk,
  input  logic              reset,
  tile_frame_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [5:0] X_LAST = 6'(TILES_X - 1);
  localparam logic [5:0] Y_LAST = 6'(TILES_Y - 1);

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [5:0]    x_q;
  logic [5:0]    y_q;
  logic [2047:0] data_q;
  logic          ready_q;
  logic          done_q;
  logic          fdone_q;

  logic [5:0]    x_d;
  logic [5:0]    y_d;
  logic          last_tile;
  logic [10:0]   wr_base;

  // Successor tile coordinates: step along the row, wrap to the next row at the right edge.
  // After the last tile this yields (0, TILES_Y), which the consumer maps to the last linear slot.
  always_comb begin
    x_d = 6'd0;
    y_d = y_q + 6'd1;
    if (x_q < X_LAST) begin
      x_d = x_q + 6'd1;
      y_d = y_q;
    end
  end

  assign last_tile = (x_q == X_LAST) && (y_q == Y_LAST);
  // Pixel n = 16*r + c lands at byte n of the tile register.
  assign wr_base   = {cnt_q, 3'b000};

  // Tile FSM: gather pixels in FILL, present the finished tile for one COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      x_q     <= 6'd0;
      y_q     <= 6'd0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.i_frame_start) begin
            state_q <= FILL;
            ready_q <= 1'b1;
            cnt_q   <= 8'd0;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
          end
        end

        FILL: begin
          if (bus.i_frame_start) begin
            // Restart the frame; the partial tile is abandoned and the pixel
            // presented in this cycle is dropped. Tile bytes are left as is.
            cnt_q <= 8'd0;
            x_q   <= 6'd0;
            y_q   <= 6'd0;
          end else if (bus.i_pixel_valid) begin
            data_q[wr_base +: 8] <= bus.i_pixel_color;
            cnt_q                <= cnt_q + 8'd1;
            if (cnt_q == 8'hFF) begin
              // Coordinates advance on this same edge so the strobe
              // carries the successor tile.
              state_q <= COMMIT;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              fdone_q <= last_tile;
              x_q     <= x_d;
              y_q     <= y_d;
            end
          end
        end

        COMMIT: begin
          // The strobe for this cycle is already on the outputs; only the
          // follow-on state is decided here.
          if (bus.i_frame_start) begin
            state_q <= FILL;
            ready_q <= 1'b1;
            cnt_q   <= 8'd0;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
          end else if (fdone_q) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end else begin
            state_q <= FILL;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pixel_ready    = ready_q;
  assign bus.o_sm_render_done = done_q;
  assign bus.o_frame_done     = fdone_q;
  assign bus.o_current_tile_x = x_q;
  assign bus.o_current_tile_y = y_q;
  assign bus.o_sm_color_data  = data_q;

endmodule

// File: tb/tb_tile_frame_writer.sv
// Randomised bench for tile_frame_writer on a reduced 5x3-tile frame.
// A tile-level model predicts ready, strobes, coordinates and tile contents.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_tile_frame_writer;

  localparam int TX = 5;
  localparam int TY = 3;
  localparam int NT = TX * TY;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tile_frame_writer_if ifc ();

  tile_frame_writer #(.TILES_X(TX), .TILES_Y(TY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 filling, 2 tile being presented this cycle.
  int phase   = 0;
  int pcnt    = 0;
  int t       = 0;
  int strobes = 0;
  int fdones  = 0;
  logic [7:0] mem [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs for the current cycle, then advance past the next rising edge.
  task automatic step(input logic fs, input logic v, input logic [7:0] col, input logic r);
    reset             = r;
    ifc.i_frame_start = fs;
    ifc.i_pixel_valid = v;
    ifc.i_pixel_color = col;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(ifc.o_pixel_ready), 64'd0);
    chk({tag, "_done"}, 64'(ifc.o_sm_render_done), 64'd0);
    chk({tag, "_fdone"}, 64'(ifc.o_frame_done), 64'd0);
    chk({tag, "_x"}, 64'(ifc.o_current_tile_x), 64'd0);
    chk({tag, "_y"}, 64'(ifc.o_current_tile_y), 64'd0);
    for (int w = 0; w < 32; w++)
      chk({tag, "_data"}, ifc.o_sm_color_data[w*64 +: 64], 64'd0);
  endtask

  task automatic run_to_commit(input string tag);
    int n = 0;
    while (phase != 2 && n < 4000) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 4000), 64'd0);
  endtask

  // Reference model and output checker.
  always @(negedge clk) begin
    int nt;
    int obs_lin;
    logic [63:0] ew;
    chk("ready", 64'(ifc.o_pixel_ready), 64'(phase == 1));
    chk("render_done", 64'(ifc.o_sm_render_done), 64'(phase == 2));
    chk("frame_done", 64'(ifc.o_frame_done), 64'(phase == 2 && t == NT - 1));
    if (ifc.o_sm_render_done === 1'b1) strobes++;
    if (ifc.o_frame_done === 1'b1) fdones++;
    if (phase == 2) begin
      nt = t + 1;
      chk("tile_x", 64'(ifc.o_current_tile_x), 64'(nt % TX));
      chk("tile_y", 64'(ifc.o_current_tile_y), 64'(nt / TX));
      obs_lin = int'(ifc.o_current_tile_y) * TX + int'(ifc.o_current_tile_x) - 1;
      chk("linear_index", 64'(obs_lin), 64'(t));
      for (int w = 0; w < 32; w++) begin
        for (int b = 0; b < 8; b++) ew[b*8 +: 8] = mem[w*8 + b];
        chk("tile_word", ifc.o_sm_color_data[w*64 +: 64], ew);
      end
      t++;
    end
    if (reset) begin
      phase = 0;
      pcnt  = 0;
      t     = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    end else if (ifc.i_frame_start) begin
      phase = 1;
      pcnt  = 0;
      t     = 0;
    end else if (phase == 1) begin
      if (ifc.i_pixel_valid) begin
        mem[pcnt] = ifc.i_pixel_color;
        if (pcnt == 255) begin
          phase = 2;
          pcnt  = 0;
        end else begin
          pcnt++;
        end
      end
    end else if (phase == 2) begin
      phase = (t == NT) ? 0 : 1;
    end
  end

  initial begin
    int s0;
    int f0;
    int n;

    // Reset state
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    check_zero("reset");
    repeat (2) step(1'b0, 1'b1, 8'h5A, 1'b0);

    // One tile, pixel value = index, valid held high
    s0 = strobes;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("single_strobes", 64'(strobes - s0), 64'd1);
    chk("single_x", 64'(ifc.o_current_tile_x), 64'd1);
    chk("single_y", 64'(ifc.o_current_tile_y), 64'd0);
    chk("byte_0", 64'(ifc.o_sm_color_data[0 +: 8]), 64'd0);
    chk("byte_77", 64'(ifc.o_sm_color_data[77*8 +: 8]), 64'd77);
    chk("byte_255", 64'(ifc.o_sm_color_data[255*8 +: 8]), 64'd255);

    // Full frame with random valid gaps
    s0 = strobes;
    f0 = fdones;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (phase != 0 && n < 20000) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      n++;
    end
    chk("frame_timeout", 64'(n >= 20000), 64'd0);
    chk("frame_strobes", 64'(strobes - s0), 64'(NT));
    chk("frame_dones", 64'(fdones - f0), 64'd1);
    chk("frame_idle_ready", 64'(ifc.o_pixel_ready), 64'd0);
    s0 = strobes;
    repeat (10) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("idle_no_strobe", 64'(strobes - s0), 64'd0);

    // Abort part-way through a tile; frame_start coincides with a valid pixel
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!(phase == 1 && t == TX + 2 && pcnt == 100) && n < 8000) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      n++;
    end
    chk("abort_reach_timeout", 64'(n >= 8000), 64'd0);
    s0 = strobes;
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    n = 0;
    while (strobes == s0 && n < 2000) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      n++;
    end
    chk("abort_timeout", 64'(n >= 2000), 64'd0);
    chk("abort_x", 64'(ifc.o_current_tile_x), 64'd1);
    chk("abort_y", 64'(ifc.o_current_tile_y), 64'd0);

    // frame_start during the commit cycle
    run_to_commit("fs_commit");
    s0 = strobes;
    step(1'b1, 1'b1, 8'h11, 1'b0);
    chk("fs_commit_strobe", 64'(strobes - s0), 64'd1);
    run_to_commit("fs_commit_next");
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fs_commit_x", 64'(ifc.o_current_tile_x), 64'd1);
    chk("fs_commit_y", 64'(ifc.o_current_tile_y), 64'd0);

    // Reset on the edge that ends a commit cycle
    run_to_commit("rst_commit");
    step(1'b0, 1'b1, 8'($urandom), 1'b1);
    check_zero("rst_commit");
    s0 = strobes;
    repeat (300) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("rst_commit_quiet", 64'(strobes - s0), 64'd0);

    // Reset in the middle of filling
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (pcnt < 50 && n < 1000) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b0);
      n++;
    end
    step(1'b0, 1'b1, 8'($urandom), 1'b1);
    check_zero("rst_fill");
    s0 = strobes;
    repeat (300) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("rst_fill_quiet", 64'(strobes - s0), 64'd0);

    // Recovery after reset
    step(1'b1, 1'b0, 8'h00, 1'b0);
    run_to_commit("recover");
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_frame_writer.md
TILE_FRAME_WRITER -- requirements
Module: tile_frame_writer

Interface
REQ-001 Parameter TILES_X, default 40, tiles per frame row (640 px / 16).
REQ-002 Parameter TILES_Y, default 30, tile rows per frame (480 px / 16).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_frame_start  input  1  one-cycle pulse that starts a new frame at tile (0,0).
REQ-006 i_pixel_valid  input  1  pixel present on i_pixel_color.
REQ-007 o_pixel_ready  output  1  block accepts a pixel this cycle.
REQ-008 i_pixel_color  input  8  256-colour pixel.
REQ-009 o_sm_render_done  output  1  one-cycle tile-write strobe to the frame buffer.
REQ-010 o_current_tile_x  output  6  successor tile x; the frame buffer writes to linear index y*40+x-1.
REQ-011 o_current_tile_y  output  6  successor tile y.
REQ-012 o_sm_color_data  output  2048  packed 16x16 tile.
REQ-013 o_frame_done  output  1  one-cycle pulse with the last tile's commit.

Function
REQ-014 The FSM SHALL have states IDLE, FILL and COMMIT.
REQ-015 IDLE behaviour: o_pixel_ready=0; i_frame_start -> FILL, pixel count=0, coordinates=(0,0).
REQ-016 FILL behaviour: o_pixel_ready=1; a pixel is accepted when i_pixel_valid && o_pixel_ready.
REQ-017 Pixel order: tile-row-major, 16 pixels per row, 16 rows per tile; the 8-bit count n = 16*r + c.
REQ-018 Packing: an accepted pixel (r,c) is stored at o_sm_color_data[(16r+c)*8 +: 8], so 64-bit read word k = 2r + c[3] holds byte c[2:0] at bits [c[2:0]*8 +: 8].
REQ-019 Accepting pixel n=255 -> COMMIT on the next edge, and the count wraps to 0.
REQ-020 COMMIT lasts exactly 1 cycle with o_pixel_ready=0.
REQ-021 COMMIT strobe: o_sm_render_done=1, and o_sm_color_data holds the complete tile stable for that cycle.
REQ-022 The coordinates SHALL advance on the same edge that enters COMMIT, so the strobe cycle presents the successor tile.
REQ-023 Coordinate advance rule: x<TILES_X-1 -> x+1; otherwise x=0 and y+1.
REQ-024 Last-tile coordinates: committing tile (39,29) presents (0,30), so the consumer's y*40+x-1 = 1199.
REQ-025 Coordinate widths: x and y are unsigned 6-bit and never exceed 39 and 30 respectively.
REQ-026 Last-tile commit: o_frame_done=1 in the same cycle as o_sm_render_done, then COMMIT -> IDLE.
REQ-027 Other commits: COMMIT -> FILL.
REQ-028 Tile-data write policy: pixels are written into the tile register in place, with no clearing between tiles, and unwritten bytes keep the previous tile's values.
REQ-029 The latency from acceptance of the 256th pixel to the o_sm_render_done assertion SHALL be 1 cycle.
REQ-030 i_frame_start in FILL: the partial tile is discarded, count=0, coordinates=(0,0), the state stays FILL, and no strobe is produced.
REQ-031 i_frame_start in COMMIT: the strobe for that cycle still completes, then FILL with count=0 and coordinates=(0,0).
REQ-032 i_frame_start in the same cycle as a pixel accept: i_frame_start wins and the pixel is dropped.
REQ-033 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-034 Reset SHALL have priority over i_frame_start.
REQ-035 On the edge where reset=1, the block SHALL enter IDLE with count=0.
REQ-036 Reset output values: o_pixel_ready=0, o_sm_render_done=0, o_frame_done=0, o_current_tile_x=0, o_current_tile_y=0, o_sm_color_data=0.
REQ-037 Reset during FILL or COMMIT SHALL abort the operation with no strobe emitted afterwards.

Verification
REQ-038 Reset released, i_frame_start pulse, 256 pixels with value n = index, valid held high -> ready drops for one cycle; a single render_done strobe occurs with tile (1,0) presented; byte n of color_data = n[7:0].
REQ-039 Full frame of 1200 tiles with random valid gaps -> exactly 1200 strobes, each with linear y*40+x-1 = 0..1199 in order; frame_done only on strobe 1200 with (0,30); state IDLE afterwards with ready=0.
REQ-040 Tile 39 of row 0 committed -> strobe presents (0,1), and y*40+x-1 = 39.
REQ-041 i_frame_start after 100 pixels of tile (5,2) -> no strobe; the next 256 pixels commit with (1,0) presented.
REQ-042 reset asserted in the COMMIT cycle's following edge and mid-FILL -> all outputs equal 0 next cycle, and no further strobes occur until i_frame_start.
REQ-043 i_frame_start and i_pixel_valid high in the same cycle -> the pixel is not counted, and the strobe follows exactly 256 later accepts.
